// File: rtl/csr_hazard_ctrl_if.sv
// rtl/csr_hazard_ctrl_if.sv - debug CSR access handshake between requester and controller
interface csr_hazard_ctrl_if;
    logic        dbg_req;
    logic        dbg_we;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_done;
    logic [31:0] dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_done, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_done, dbg_rdata
    );
endinterface

// File: rtl/csr_hazard_ctrl.sv
// rtl/csr_hazard_ctrl.sv - CSR write scoreboard, ID hazard stall and debug CSR port arbiter
// Option: CSR_SERIALIZE_EN makes any in-flight CSR write stall every ID CSR access.
module csr_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_csr_valid,
    input  logic              id_csr_write,
    input  logic [11:0]       id_csr_addr,
    input  logic              bubbleE,
    input  logic              flushE,
    output logic              csr_stallD,
    output logic              csr_flushE,
    csr_hazard_ctrl_if.slave  dbg,
    output logic              csr_dbg_sel,
    output logic [11:0]       csr_dbg_addr,
    output logic              csr_dbg_we,
    output logic [31:0]       csr_dbg_wdata,
    input  logic [31:0]       csr_rdata,
    output logic [CNT_W-1:0]  csr_stall_cnt
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        sb_valid_q, sb_valid_d;
    logic [2:0][11:0]  sb_addr_q, sb_addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        hit;
    logic              hazard;
    logic              access;

    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++) begin
`ifdef CSR_SERIALIZE_EN
            hit[i] = sb_valid_q[i];
`else
            hit[i] = sb_valid_q[i] && (sb_addr_q[i] == id_csr_addr);
`endif
        end
    end

    assign hazard     = id_csr_valid && (|hit);
    assign csr_stallD = (state_q != S_IDLE) || hazard;
    assign csr_flushE = csr_stallD;

    // The stalled ID instruction is replaced by a bubble, so it never enters the scoreboard.
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_addr_d  = sb_addr_q;
        if (!bubbleE) begin
            sb_valid_d[0] = !(flushE || csr_flushE) && id_csr_valid && id_csr_write;
            sb_addr_d[0]  = id_csr_addr;
            sb_valid_d[1] = sb_valid_q[0];
            sb_addr_d[1]  = sb_addr_q[0];
            sb_valid_d[2] = sb_valid_q[1];
            sb_addr_d[2]  = sb_addr_q[1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (dbg.dbg_req) state_d = S_DRAIN;
            S_DRAIN:  if (sb_valid_q == 3'b000) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign access  = (state_q == S_ACCESS);
    assign rdata_d = access ? csr_rdata : rdata_q;
    // Only pipeline hazard stalls are counted; debug drain stalls are excluded.
    assign cnt_d   = (state_q == S_IDLE && hazard && cnt_q != {CNT_W{1'b1}})
                     ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sb_valid_q <= '0;
            sb_addr_q  <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sb_valid_q <= sb_valid_d;
            sb_addr_q  <= sb_addr_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign csr_dbg_sel   = access;
    assign csr_dbg_we    = access && dbg.dbg_we;
    assign csr_dbg_addr  = access ? dbg.dbg_addr : 12'h000;
    assign csr_dbg_wdata = access ? dbg.dbg_wdata : 32'h0;
    assign dbg.dbg_gnt   = access;
    assign dbg.dbg_done  = (state_q == S_DONE);
    assign dbg.dbg_rdata = rdata_q;
    assign csr_stall_cnt = cnt_q;
endmodule
